rtc_counter: RTL and testbench

Time-of-day counter that consumes the slow square wave produced by the clock divider (divided_clk), sampled as a plain data input in the clk domain. Each qualifying edge of that input advances an hours/minutes/seconds count with cascaded wrap-around. It emits single-cycle carry pulses and supports a validated time-set handshake. Sits between the divider and display/alarm logic.

---
 rtl/rtc_counter_pkg.sv | 26 ++
 rtl/rtc_counter_if.sv | 28 ++
 rtl/rtc_counter_mod_counter.sv | 39 +++
 rtl/rtc_counter.sv | 109 ++++++++++
 tb/tb_rtc_counter.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/rtc_counter_pkg.sv
// rtc_counter_pkg
//   Shared time-of-day definitions: field widths, default moduli, a packed
//   hh:mm:ss record and a range-check helper. Display and alarm blocks import
//   this package so that every block agrees on the field layout.
package rtc_counter_pkg;

   localparam int HOUR_W       = 5;
   localparam int MIN_W        = 6;
   localparam int SEC_W        = 6;

   localparam int HOUR_MOD_DEF = 24;
   localparam int MIN_MOD_DEF  = 60;
   localparam int SEC_MOD_DEF  = 60;

   typedef struct packed {
      logic [HOUR_W-1:0] hh;
      logic [MIN_W-1:0]  mm;
      logic [SEC_W-1:0]  ss;
   } tod_t;

   // True when a field value is a legal count for the given modulus.
   function automatic logic below_mod(input logic [6:0] val, input int modv);
      return int'(val) < modv;
   endfunction

endpackage

// File: rtl/rtc_counter_if.sv
// rtc_counter_if
//   Time-set handshake bundle.
//   set_valid        : requester asks to load set_hh:set_mm:set_ss
//   set_hh/mm/ss     : time to load
//   set_ready        : counter can accept a set this cycle
//   set_err          : one-cycle pulse, accepted set was out of range
//   master modport = requester side, slave modport = rtc_counter side.
interface rtc_counter_if;
   import rtc_counter_pkg::*;

   logic              set_valid;
   logic              set_ready;
   logic              set_err;
   logic [HOUR_W-1:0] set_hh;
   logic [MIN_W-1:0]  set_mm;
   logic [SEC_W-1:0]  set_ss;

   modport master (
      output set_valid, set_hh, set_mm, set_ss,
      input  set_ready, set_err
   );

   modport slave (
      input  set_valid, set_hh, set_mm, set_ss,
      output set_ready, set_err
   );

endinterface

// File: rtl/rtc_counter_mod_counter.sv
// mod_counter
//   Modulo-MOD counter used for one time-of-day field.
//   clk, rst  : clock, synchronous active-high reset (count -> 0)
//   inc       : advance by one this cycle
//   load      : load load_val (has priority over inc)
//   load_val  : value to load
//   count     : current value, always 0..MOD-1
//   wrap      : combinational, high when this inc rolls count back to 0;
//               feeds the inc of the next field up the chain
module mod_counter #(
   parameter int MOD   = 60,
   parameter int WIDTH = 6
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] count,
   output logic             wrap
);

   logic at_top;

   // Compare before incrementing so the field never holds MOD.
   assign at_top = (count == WIDTH'(MOD - 1));
   assign wrap   = inc & ~load & at_top;

   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (inc) begin
         count <= at_top ? '0 : count + WIDTH'(1);
      end
   end

endmodule

// File: rtl/rtc_counter.sv
// rtc_counter
//   Time-of-day counter advanced by edges of the divider output tick_in,
//   which is already in the clk domain and sampled as plain data.
//   clk, rst        : clock, synchronous active-high reset
//   tick_in         : divided clock level; each qualifying edge = 1 second
//   enable          : 1 counts, 0 freezes time and drops edges
//   set_bus (slave) : time-set handshake (valid/ready, hh/mm/ss, err)
//   hours/minutes/seconds : current time
//   sec/min/hour/day_pulse : one-cycle carry pulses, registered
//   BOTH_EDGES=1 counts every toggle, 0 counts rising edges only.
//   Moduli must fit the fixed field widths (HOUR_MOD<=32, MIN/SEC_MOD<=64).
module rtc_counter
   import rtc_counter_pkg::*;
#(
   parameter bit BOTH_EDGES = 1'b1,
   parameter int SEC_MOD    = SEC_MOD_DEF,
   parameter int MIN_MOD    = MIN_MOD_DEF,
   parameter int HOUR_MOD   = HOUR_MOD_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              tick_in,
   input  logic              enable,
   rtc_counter_if.slave      set_bus,
   output logic [HOUR_W-1:0] hours,
   output logic [MIN_W-1:0]  minutes,
   output logic [SEC_W-1:0]  seconds,
   output logic              sec_pulse,
   output logic              min_pulse,
   output logic              hour_pulse,
   output logic              day_pulse
);

   tod_t set_tod;
   logic tick_q;
   logic tick_edge;
   logic accept;
   logic range_ok;
   logic load;
   logic inc;
   logic sec_wrap;
   logic min_wrap;
   logic hour_wrap;

   assign set_tod   = '{hh: set_bus.set_hh, mm: set_bus.set_mm, ss: set_bus.set_ss};

   assign tick_edge = BOTH_EDGES ? (tick_in ^ tick_q) : (tick_in & ~tick_q);

   assign accept    = set_bus.set_valid & set_bus.set_ready;
   assign range_ok  = below_mod(7'(set_tod.hh), HOUR_MOD) &
                      below_mod(7'(set_tod.mm), MIN_MOD)  &
                      below_mod(7'(set_tod.ss), SEC_MOD);
   assign load      = accept & range_ok;
   // A loaded time swallows a coincident edge; a rejected set does not.
   assign inc       = tick_edge & enable & ~load;

   mod_counter #(.MOD(SEC_MOD), .WIDTH(SEC_W)) u_sec (
      .clk      (clk),
      .rst      (rst),
      .inc      (inc),
      .load     (load),
      .load_val (set_tod.ss),
      .count    (seconds),
      .wrap     (sec_wrap)
   );

   mod_counter #(.MOD(MIN_MOD), .WIDTH(MIN_W)) u_min (
      .clk      (clk),
      .rst      (rst),
      .inc      (sec_wrap),
      .load     (load),
      .load_val (set_tod.mm),
      .count    (minutes),
      .wrap     (min_wrap)
   );

   mod_counter #(.MOD(HOUR_MOD), .WIDTH(HOUR_W)) u_hour (
      .clk      (clk),
      .rst      (rst),
      .inc      (min_wrap),
      .load     (load),
      .load_val (set_tod.hh),
      .count    (hours),
      .wrap     (hour_wrap)
   );

   // tick_q follows tick_in even while disabled, so re-enabling never
   // sees a stale edge. set_ready drops for one cycle after any accepted set.
   always_ff @(posedge clk) begin
      if (rst) begin
         tick_q            <= 1'b0;
         set_bus.set_ready <= 1'b0;
         set_bus.set_err   <= 1'b0;
         sec_pulse         <= 1'b0;
         min_pulse         <= 1'b0;
         hour_pulse        <= 1'b0;
         day_pulse         <= 1'b0;
      end else begin
         tick_q            <= tick_in;
         set_bus.set_ready <= ~accept;
         set_bus.set_err   <= accept & ~range_ok;
         sec_pulse         <= inc;
         min_pulse         <= sec_wrap;
         hour_pulse        <= min_wrap;
         day_pulse         <= hour_wrap;
      end
   end

endmodule

// File: tb/tb_rtc_counter.sv
// tb_rtc_counter
//   Directed, table-driven bench for rtc_counter. Two instances share the
//   same stimulus: dut1 counts both edges, dut0 counts rising edges only.
module tb_rtc_counter;
   import rtc_counter_pkg::*;

   typedef struct {
      logic       rst;
      logic       tick;
      logic       en;
      logic       sv;
      logic [4:0] hh;
      logic [5:0] mm;
      logic [5:0] ss;
      logic [4:0] e_h;
      logic [5:0] e_m;
      logic [5:0] e_s;
      logic [3:0] e_pulse;   // {sec, min, hour, day}
      logic       e_err;
      logic       e_rdy;
      logic       chk0;      // also check dut0 seconds
      logic [5:0] e_s0;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       tick_in = 1'b0;
   logic       enable = 1'b1;
   logic       set_valid = 1'b0;
   logic [4:0] set_hh = '0;
   logic [5:0] set_mm = '0;
   logic [5:0] set_ss = '0;

   logic [4:0] hours1, hours0;
   logic [5:0] minutes1, minutes0, seconds1, seconds0;
   logic       sp1, mp1, hp1, dp1, sp0, mp0, hp0, dp0;

   vec_t vq[$];
   int   n_vec  = 0;
   int   n_fail = 0;

   rtc_counter_if sb1();
   rtc_counter_if sb0();

   assign sb1.set_valid = set_valid;
   assign sb1.set_hh    = set_hh;
   assign sb1.set_mm    = set_mm;
   assign sb1.set_ss    = set_ss;
   assign sb0.set_valid = set_valid;
   assign sb0.set_hh    = set_hh;
   assign sb0.set_mm    = set_mm;
   assign sb0.set_ss    = set_ss;

   always #5 clk = ~clk;

   rtc_counter #(.BOTH_EDGES(1'b1)) dut1 (
      .clk        (clk),
      .rst        (rst),
      .tick_in    (tick_in),
      .enable     (enable),
      .set_bus    (sb1),
      .hours      (hours1),
      .minutes    (minutes1),
      .seconds    (seconds1),
      .sec_pulse  (sp1),
      .min_pulse  (mp1),
      .hour_pulse (hp1),
      .day_pulse  (dp1)
   );

   rtc_counter #(.BOTH_EDGES(1'b0)) dut0 (
      .clk        (clk),
      .rst        (rst),
      .tick_in    (tick_in),
      .enable     (enable),
      .set_bus    (sb0),
      .hours      (hours0),
      .minutes    (minutes0),
      .seconds    (seconds0),
      .sec_pulse  (sp0),
      .min_pulse  (mp0),
      .hour_pulse (hp0),
      .day_pulse  (dp0)
   );

   task automatic addv(input logic r, input logic t, input logic en, input logic sv,
                       input int hh, input int mm, input int ss,
                       input int eh, input int em, input int es,
                       input logic [3:0] ep, input logic eerr, input logic erdy,
                       input logic c0, input int es0);
      vec_t v;
      v.rst = r; v.tick = t; v.en = en; v.sv = sv;
      v.hh = 5'(hh); v.mm = 6'(mm); v.ss = 6'(ss);
      v.e_h = 5'(eh); v.e_m = 6'(em); v.e_s = 6'(es);
      v.e_pulse = ep; v.e_err = eerr; v.e_rdy = erdy;
      v.chk0 = c0; v.e_s0 = 6'(es0);
      vq.push_back(v);
   endtask

   task automatic apply(input vec_t v, input string name);
      logic [22:0] act, exp;
      rst = v.rst; tick_in = v.tick; enable = v.en; set_valid = v.sv;
      set_hh = v.hh; set_mm = v.mm; set_ss = v.ss;
      @(posedge clk);
      #1;
      act = {hours1, minutes1, seconds1, sp1, mp1, hp1, dp1, sb1.set_err, sb1.set_ready};
      exp = {v.e_h, v.e_m, v.e_s, v.e_pulse, v.e_err, v.e_rdy};
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d:%0d:%0d pulses=%b err=%b rdy=%b, want %0d:%0d:%0d pulses=%b err=%b rdy=%b",
                  name, hours1, minutes1, seconds1, {sp1, mp1, hp1, dp1}, sb1.set_err, sb1.set_ready,
                  v.e_h, v.e_m, v.e_s, v.e_pulse, v.e_err, v.e_rdy);
      end
      if (v.chk0) begin
         n_vec++;
         if (seconds0 !== v.e_s0) begin
            n_fail++;
            $display("FAIL %s_rising_only: seconds got %0d want %0d", name, seconds0, v.e_s0);
         end
      end
   endtask

   initial begin
      vec_t v;
      int   budget;

      //    rst t en sv hh mm ss | H  M  S  pulses  err rdy c0 s0
      // reset, then idle low
      addv(1, 0, 1, 0, 0, 0, 0,  0, 0, 0, 4'b0000, 0, 0, 0, 0);
      for (int i = 0; i < 10; i++)
         addv(0, 0, 1, 0, 0, 0, 0,  0, 0, 0, 4'b0000, 0, 1, (i == 9), 0);
      // three toggles
      addv(0, 1, 1, 0, 0, 0, 0,  0, 0, 1, 4'b1000, 0, 1, 0, 0);
      addv(0, 0, 1, 0, 0, 0, 0,  0, 0, 2, 4'b1000, 0, 1, 0, 0);
      addv(0, 1, 1, 0, 0, 0, 0,  0, 0, 3, 4'b1000, 0, 1, 0, 0);
      addv(0, 1, 1, 0, 0, 0, 0,  0, 0, 3, 4'b0000, 0, 1, 1, 2);
      // set 23:59:59, then one toggle rolls the day
      addv(0, 1, 1, 1, 23, 59, 59, 23, 59, 59, 4'b0000, 0, 0, 0, 0);
      addv(0, 1, 1, 0, 0, 0, 0,  23, 59, 59, 4'b0000, 0, 1, 0, 0);
      addv(0, 0, 1, 0, 0, 0, 0,  0, 0, 0, 4'b1111, 0, 1, 0, 0);
      addv(0, 0, 1, 0, 0, 0, 0,  0, 0, 0, 4'b0000, 0, 1, 0, 0);
      // out-of-range set 12:60:00
      addv(0, 0, 1, 1, 12, 60, 0, 0, 0, 0, 4'b0000, 1, 0, 0, 0);
      addv(0, 0, 1, 0, 0, 0, 0,  0, 0, 0, 4'b0000, 0, 1, 0, 0);
      // valid set, then set_valid while not ready is ignored
      addv(0, 0, 1, 1, 1, 2, 3,  1, 2, 3, 4'b0000, 0, 0, 0, 0);
      addv(0, 0, 1, 1, 12, 60, 0, 1, 2, 3, 4'b0000, 0, 1, 0, 0);
      addv(0, 0, 1, 0, 0, 0, 0,  1, 2, 3, 4'b0000, 0, 1, 0, 0);
      // accepted set with coincident edge: set wins
      addv(0, 1, 1, 1, 10, 20, 30, 10, 20, 30, 4'b0000, 0, 0, 0, 0);
      addv(0, 1, 1, 0, 0, 0, 0,  10, 20, 30, 4'b0000, 0, 1, 0, 0);
      // rejected set with coincident edge: increment proceeds
      addv(0, 0, 1, 1, 12, 60, 0, 10, 20, 31, 4'b1000, 1, 0, 0, 0);
      addv(0, 0, 1, 0, 0, 0, 0,  10, 20, 31, 4'b0000, 0, 1, 0, 0);
      // disabled: five toggles dropped
      addv(0, 1, 0, 0, 0, 0, 0,  10, 20, 31, 4'b0000, 0, 1, 0, 0);
      addv(0, 0, 0, 0, 0, 0, 0,  10, 20, 31, 4'b0000, 0, 1, 0, 0);
      addv(0, 1, 0, 0, 0, 0, 0,  10, 20, 31, 4'b0000, 0, 1, 0, 0);
      addv(0, 0, 0, 0, 0, 0, 0,  10, 20, 31, 4'b0000, 0, 1, 0, 0);
      addv(0, 1, 0, 0, 0, 0, 0,  10, 20, 31, 4'b0000, 0, 1, 0, 0);
      // set accepted while disabled, then re-enable with level held high
      addv(0, 1, 0, 1, 5, 7, 9,  5, 7, 9, 4'b0000, 0, 0, 0, 0);
      addv(0, 1, 1, 0, 0, 0, 0,  5, 7, 9, 4'b0000, 0, 1, 0, 0);
      // reset with concurrent set and edge
      addv(1, 0, 1, 1, 1, 2, 3,  0, 0, 0, 4'b0000, 0, 0, 0, 0);
      addv(0, 0, 1, 0, 0, 0, 0,  0, 0, 0, 4'b0000, 0, 1, 0, 0);
      addv(0, 1, 1, 0, 0, 0, 0,  0, 0, 1, 4'b1000, 0, 1, 0, 0);

      @(posedge clk);
      #1;
      foreach (vq[i]) apply(vq[i], $sformatf("vec%0d", i));

      // Hand sequence: hour carry without day carry, 00:59:58 -> 01:00:00.
      v = vq[$];
      v.sv = 1; v.hh = 0; v.mm = 59; v.ss = 58; v.tick = 1;
      v.e_h = 0; v.e_m = 59; v.e_s = 58; v.e_pulse = 4'b0000; v.e_err = 0; v.e_rdy = 0;
      apply(v, "hour_carry_set");
      v.sv = 0; v.tick = 0;
      v.e_s = 59; v.e_pulse = 4'b1000; v.e_rdy = 1;
      apply(v, "hour_carry_59");
      v.tick = 1;
      v.e_h = 1; v.e_m = 0; v.e_s = 0; v.e_pulse = 4'b1110;
      apply(v, "hour_carry_roll");

      // Hand sequence: after an accepted set, set_ready must come back
      // within a bounded number of cycles.
      set_valid = 1; set_hh = 3; set_mm = 4; set_ss = 5;
      @(posedge clk);
      #1;
      set_valid = 0;
      budget = 0;
      while (sb1.set_ready !== 1'b1 && budget < 5) begin
         @(posedge clk);
         #1;
         budget++;
      end
      n_vec++;
      if (sb1.set_ready !== 1'b1 || budget != 1 || hours1 !== 5'd3 || minutes1 !== 6'd4 || seconds1 !== 6'd5) begin
         n_fail++;
         $display("FAIL ready_return: ready=%b after %0d cycles time %0d:%0d:%0d, want ready=1 after 1 cycle time 3:4:5",
                  sb1.set_ready, budget, hours1, minutes1, seconds1);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
